// File: rtl/tpu_pkg.sv
// Shared TPU definitions: default sizes, width helpers, drain FSM states.
package tpu_pkg;
  localparam int N_DEF     = 4;
  localparam int SUM_W_DEF = 32;

  // Flat element index width, floored at 1 so a 1x1 matrix still has a port.
  function automatic int idx_w(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

  // Width of one row/column counter, floored at 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {IDLE, STREAM} drain_state_e;
endpackage

// File: rtl/tpu_rc_counter.sv
// Two nested mod-N counters (outer/inner). Exposes the current position and
// the position after one step, so a caller can register the next element
// on the same edge that the counter advances.
module tpu_rc_counter
  import tpu_pkg::*;
#(
  parameter  int N  = N_DEF,
  localparam int CW = cnt_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          step,
  output logic [CW-1:0] outer,
  output logic [CW-1:0] inner,
  output logic [CW-1:0] nxt_outer,
  output logic [CW-1:0] nxt_inner,
  output logic          last,
  output logic          nxt_last
);
  localparam logic [CW-1:0] MAXV = CW'(N - 1);

  // Next position: inner wraps at N-1 and carries into outer.
  always_comb begin
    nxt_inner = (inner == MAXV) ? '0 : inner + 1'b1;
    nxt_outer = outer;
    if (inner == MAXV) nxt_outer = (outer == MAXV) ? '0 : outer + 1'b1;
    last      = (outer == MAXV) && (inner == MAXV);
    nxt_last  = (nxt_outer == MAXV) && (nxt_inner == MAXV);
  end

  // Position register; clear restarts a job at (0,0).
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      outer <= '0;
      inner <= '0;
    end else if (step) begin
      outer <= nxt_outer;
      inner <= nxt_inner;
    end
  end
endmodule

// File: rtl/tpu_c_drain.sv
// Streams the N*N result matrix out one element per valid/ready handshake,
// in row-major or column-major order chosen at job start.
module tpu_c_drain
  import tpu_pkg::*;
#(
  parameter  int N     = N_DEF,
  parameter  int SUM_W = SUM_W_DEF,
  localparam int IDX_W = idx_w(N),
  localparam int CW    = cnt_w(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 col_major,
  input  logic [SUM_W*N*N-1:0] c_flat,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [SUM_W-1:0]     m_data,
  output logic [IDX_W-1:0]     m_index,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done
);
  drain_state_e state;
  logic         col_q;
  logic         hs, clear, step, nxt_last, cur_last;
  logic [CW-1:0]    outer, inner, nxt_outer, nxt_inner, nxt_r, nxt_c;
  logic [IDX_W-1:0] nxt_idx;
  logic [N*N-1:0][SUM_W-1:0] elems;

  // Same bits as c_flat, viewed as an element array (no snapshot is taken).
  assign elems = c_flat;

  assign hs    = m_valid & m_ready;
  assign clear = (state == IDLE) & start;
  assign step  = (state == STREAM) & hs & ~m_last;

  tpu_rc_counter #(.N(N)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .step      (step),
    .outer     (outer),
    .inner     (inner),
    .nxt_outer (nxt_outer),
    .nxt_inner (nxt_inner),
    .last      (cur_last),
    .nxt_last  (nxt_last)
  );

  // Map counter position to (r, c); column-major swaps the loop nesting.
  always_comb begin
    nxt_r   = col_q ? nxt_inner : nxt_outer;
    nxt_c   = col_q ? nxt_outer : nxt_inner;
    nxt_idx = IDX_W'(nxt_r) * IDX_W'(N) + IDX_W'(nxt_c);
  end

  // Drain FSM with registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      col_q   <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_index <= '0;
      m_last  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            col_q   <= col_major;
            m_data  <= elems[0];
            m_index <= '0;
            m_valid <= 1'b1;
            m_last  <= (N == 1);
            busy    <= 1'b1;
            state   <= STREAM;
          end
        end
        STREAM: begin
          if (hs) begin
            if (m_last) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= IDLE;
            end else begin
              m_data  <= elems[nxt_idx];
              m_index <= nxt_idx;
              m_last  <= nxt_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused;
  assign unused = cur_last ^ ^outer ^ ^inner;
endmodule

// File: tb/tb_tpu_c_drain.sv
// Directed bench for tpu_c_drain: orders, backpressure, start filtering,
// mid-stream reset, and a 1x1 instance.
module tb_tpu_c_drain;
  logic          clk = 1'b0;
  logic          rst, start, col_major, m_ready;
  logic [511:0]  c_flat;
  logic          m_valid, m_last, busy, done;
  logic [31:0]   m_data;
  logic [3:0]    m_index;

  logic          start1, ready1;
  logic [31:0]   c_flat1;
  logic          valid1, last1, busy1, done1;
  logic [31:0]   data1;
  logic [0:0]    index1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tpu_c_drain #(.N(4), .SUM_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .col_major(col_major),
    .c_flat(c_flat), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_index(m_index), .m_last(m_last), .busy(busy), .done(done)
  );

  tpu_c_drain #(.N(1), .SUM_W(32)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .col_major(1'b0),
    .c_flat(c_flat1), .m_valid(valid1), .m_ready(ready1), .m_data(data1),
    .m_index(index1), .m_last(last1), .busy(busy1), .done(done1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat k of a job: index is k in row-major, (k%4)*4 + k/4 in column-major.
  task automatic expect_beat(input int k, input bit col);
    int idx;
    idx = col ? ((k % 4) * 4 + k / 4) : k;
    chk($sformatf("valid[%0d]", k), 64'(m_valid), 64'd1);
    chk($sformatf("index[%0d]", k), 64'(m_index), 64'(idx));
    chk($sformatf("data[%0d]", k),  64'(m_data),  64'(32'h100 + idx));
    chk($sformatf("last[%0d]", k),  64'(m_last),  64'(k == 15));
    chk($sformatf("busy[%0d]", k),  64'(busy),    64'd1);
    chk($sformatf("done[%0d]", k),  64'(done),    64'd0);
  endtask

  task automatic drain_all(input bit col);
    m_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      expect_beat(k, col);
      tick();
    end
    chk("end_valid", 64'(m_valid), 64'd0);
    chk("end_done",  64'(done),    64'd1);
    chk("end_busy",  64'(busy),    64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; col_major = 1'b0; m_ready = 1'b0;
    start1 = 1'b0; ready1 = 1'b0; c_flat1 = 32'hDEADBEEF;
    for (int i = 0; i < 16; i++) c_flat[i*32 +: 32] = 32'h100 + i;
    tick(); tick();
    rst = 1'b0;

    // reset values
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_data",  64'(m_data),  64'd0);
    chk("rst_index", 64'(m_index), 64'd0);
    chk("rst_last",  64'(m_last),  64'd0);
    chk("rst_busy",  64'(busy),    64'd0);
    chk("rst_done",  64'(done),    64'd0);

    // row-major, ready held high
    m_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    drain_all(1'b0);
    tick();
    chk("done_pulse_once", 64'(done), 64'd0);

    // column-major; col_major is only sampled at start
    col_major = 1'b1;
    start = 1'b1; tick(); start = 1'b0; col_major = 1'b0;
    drain_all(1'b1);
    tick();

    // backpressure: ready pattern 1,0,0,1
    begin
      int k, cyc;
      k = 0; cyc = 0;
      start = 1'b1; tick(); start = 1'b0;
      while (k < 16 && cyc < 200) begin
        m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        expect_beat(k, 1'b0);
        tick();
        if (m_ready) k++;
        cyc++;
      end
      chk("bp_beats", 64'(k), 64'd16);
      chk("bp_done",  64'(done), 64'd1);
      chk("bp_valid", 64'(m_valid), 64'd0);
    end
    m_ready = 1'b1;
    tick();

    // start mid-stream ignored, then start in the done cycle accepted
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      expect_beat(k, 1'b0);
      start = (k == 5);
      tick();
      start = 1'b0;
    end
    chk("ms_done", 64'(done), 64'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("rs_valid", 64'(m_valid), 64'd1);
    chk("rs_data",  64'(m_data),  64'h100);
    chk("rs_index", 64'(m_index), 64'd0);
    chk("rs_done",  64'(done),    64'd0);
    tick();
    for (int k = 1; k < 16; k++) begin
      expect_beat(k, 1'b0);
      tick();
    end
    chk("rs_end_done", 64'(done), 64'd1);
    tick();

    // reset mid-stream at beat 7 with ready low
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      expect_beat(k, 1'b0);
      tick();
    end
    expect_beat(7, 1'b0);
    m_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_valid", 64'(m_valid), 64'd0);
    chk("mr_data",  64'(m_data),  64'd0);
    chk("mr_index", 64'(m_index), 64'd0);
    chk("mr_last",  64'(m_last),  64'd0);
    chk("mr_busy",  64'(busy),    64'd0);
    chk("mr_done",  64'(done),    64'd0);
    start = 1'b1; tick(); start = 1'b0;
    drain_all(1'b0);
    tick();

    // 1x1 instance: single beat with last
    ready1 = 1'b1;
    start1 = 1'b1; tick(); start1 = 1'b0;
    chk("n1_valid", 64'(valid1), 64'd1);
    chk("n1_data",  64'(data1),  64'hDEADBEEF);
    chk("n1_index", 64'(index1), 64'd0);
    chk("n1_last",  64'(last1),  64'd1);
    chk("n1_busy",  64'(busy1),  64'd1);
    tick();
    chk("n1_valid_end", 64'(valid1), 64'd0);
    chk("n1_done",      64'(done1),  64'd1);
    chk("n1_busy_end",  64'(busy1),  64'd0);
    tick();
    chk("n1_done_end",  64'(done1),  64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tpu_c_drain.md
Name: tpu_c_drain

Overview:
- Output stage directly downstream of the A/B/C buffer block.
- Consumes the packed result matrix `c_flat` and streams its N*N elements out over a valid/ready interface, one element per handshake.
- Emits elements in row-major or column-major order, selected per job.
- Provides `busy` so the top-level controller holds off a new C capture while a drain is in progress.

Parameters:
- N, 4, matrix dimension; the block streams N*N elements per job.
- SUM_W, 32, width of one result element.
- IDX_W, $clog2(N*N), localparam; width of the element index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle request to drain the C matrix; honoured only in IDLE.
- col_major  in  1  order select, sampled when start is accepted; 0 = row-major, 1 = column-major.
- c_flat  in  SUM_W*N*N  packed C matrix; element i (= r*N+c) occupies bits [i*SUM_W +: SUM_W].
- m_valid  out  1  stream data valid.
- m_ready  in  1  downstream ready.
- m_data  out  SUM_W  current element value.
- m_index  out  IDX_W  row-major flat index (r*N+c) of the element on m_data.
- m_last  out  1  high with the final element of a job.
- busy  out  1  high from the cycle after start is accepted until the cycle after the final handshake.
- done  out  1  one-cycle pulse in the cycle after the final handshake.

Behaviour:
- Clocking and reset:
  - Single clock; reset is synchronous and active-high.
  - All state updates on posedge clk.
- Reset values: m_valid=0, m_data=0, m_index=0, m_last=0, busy=0, done=0, state=IDLE, counters=0.
- Reset mid-stream: the block enters IDLE on the next edge and drops m_valid without a handshake. This is the only case in which valid may fall unaccepted.
- FSM states: IDLE, STREAM.
- IDLE:
  - done deasserts after its single cycle.
  - On start=1:
    - latch col_major;
    - load outer/inner counters to 0;
    - register element 0 into m_data/m_index;
    - set m_valid=1 and busy=1;
    - m_last=1 only if N*N==1;
    - go to STREAM.
  - Latency: start at cycle t gives m_valid=1 at t+1.
- STREAM:
  - Handshake = m_valid & m_ready.
  - With no handshake, m_data, m_index and m_last hold stable and m_valid stays 1.
  - On a non-final handshake, the next element is registered on the same edge. This gives zero-bubble throughput of one element per cycle while m_ready=1.
  - On the final handshake (m_last=1):
    - m_valid=0, m_last=0, busy=0 and done=1 on the next cycle;
    - go to IDLE.
- Ordering:
  - Row-major: r is the outer index and c the inner; index = r*N+c, i.e. 0,1,2,...
  - Column-major: c is the outer index and r the inner; index = r*N+c. For N=4: 0,4,8,12,1,5,...
  - Inner counter wraps at N-1 and increments the outer counter.
  - m_last = (outer==N-1 && inner==N-1) for the element being presented.
- m_data = c_flat[m_index*SUM_W +: SUM_W], sampled at the edge the element is loaded.
  - c_flat must stay stable while busy=1; the controller gates capture_c with busy.
  - The block does not snapshot the whole matrix.
- start while busy=1: ignored, with no effect on the current stream.
- start in the same cycle as done=1 (state is IDLE): accepted normally; m_valid returns one cycle later.
- No arithmetic on the data: m_data is a bit-exact copy of the element.

Decomposition:
- Shared package tpu_pkg:
  - default N and SUM_W constants;
  - IDX_W helper function;
  - drain state enum (IDLE, STREAM).
- One small sub-module is natural: tpu_rc_counter.
  - Two nested mod-N counters with a swap for column-major.
  - Outputs r, c and last.
  - Reusable by a future A/B loader.

Test Plan:
- N=4, element i = 32'h100+i, col_major=0, m_ready held 1, start pulse → beats 0x100..0x10F on 16 consecutive cycles starting one cycle after start; m_last on beat 16 only; done the following cycle; busy high for exactly 16 cycles.
- Same data, col_major=1 → m_index sequence 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15; m_data = 0x100+m_index.
- Backpressure: m_ready toggles 1,0,0,1 repeating → m_data/m_index/m_last stable through each stall; no beat dropped or duplicated; still 16 beats in order.
- start asserted again mid-stream at beat 5 → ignored; sequence continues unchanged to 0x10F with one done pulse. Then start in the done cycle → new stream; first beat 0x100 on the next cycle.
- rst asserted at beat 7 with m_ready=0 → next cycle all outputs at reset values; a subsequent start restarts from index 0.
- N=1 instance, c_flat=32'hDEADBEEF → a single beat with m_last=1, then done one cycle later.
